pcie_ats_inv_requester: RTL and testbench

PCIE_ATS_INV_REQUESTER -- requirements
Module: pcie_ats_inv_requester

---
 rtl/pcie_ats_inv_requester.sv | 150 +++++++++++++++
 tb/tb_pcie_ats_inv_requester.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_ats_inv_requester.sv
// pcie_ats_inv_requester: issues PCIe ATS invalidate requests on RQ and retires them from CQ completions.
// Ports: cmd_* invalidate command in; rq_axis_* request stream out; cq_axis_* passive completion tap;
// inv_done/done_itag/spurious/timeout single-cycle status pulses; outstanding_cnt/idle occupancy.
// Define PCIE_ATS_INV_TIMEOUT_EN to build the outstanding timer that drops all ITags after TIMEOUT_CYCLES.
module pcie_ats_inv_requester #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_TUSER_WIDTH = 229,
  parameter int RQ_AXIS_TUSER_W = 183,
  parameter logic [7:0] INV_REQ_CODE = 8'h14,
  parameter logic [7:0] INV_CPL_CODE = 8'h30,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [63:0]                  cmd_addr,
  input  logic                         cmd_s,
  input  logic [15:0]                  cmd_dest_id,
  input  logic [15:0]                  req_id,
  output logic [AXIS_DATA_WIDTH-1:0]   rq_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] rq_axis_tkeep,
  output logic                         rq_axis_tvalid,
  output logic                         rq_axis_tlast,
  output logic [RQ_AXIS_TUSER_W-1:0]   rq_axis_tuser,
  input  logic                         rq_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]   cq_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] cq_axis_tkeep,
  input  logic                         cq_axis_tvalid,
  input  logic                         cq_axis_tready,
  input  logic [AXIS_TUSER_WIDTH-1:0]  cq_axis_tuser,
  output logic                         inv_done,
  output logic [4:0]                   done_itag,
  output logic                         spurious,
  output logic                         timeout,
  output logic [5:0]                   outstanding_cnt,
  output logic                         idle
);
  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam logic [KEEP_W-1:0] KEEP = KEEP_W'(64'h0000_0000_00FF_FFFF);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [31:0] bitmap_q, bitmap_d, set_mask, clr_mask;
  logic [4:0] itag_q, itag_d, alloc_tag, cpl_tag;
  logic [51:0] addr_q, addr_d;
  logic s_q, s_d;
  logic [15:0] dest_q, dest_d;
  logic [5:0] cnt_q, cnt_d;
  logic done_q, spur_q;
  logic [4:0] done_itag_q;
  logic cmd_fire, cpl_hit, cpl_ok, send, hit;
  wire unused_ok = ^{cq_axis_tdata, cq_axis_tkeep, cq_axis_tuser, 32'(TIMEOUT_CYCLES)};
  always_ff @(posedge clk)
    state_q <= !rst ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && cmd_fire) state_d = SEND;
    if (state_q == SEND && rq_axis_tready) state_d = IDLE;
  end
  always_comb begin
    send = rst && state_q == SEND;
    cmd_ready = rst && state_q == IDLE && !(&bitmap_q);
    idle = state_q == IDLE && cnt_q == 6'd0;
    rq_axis_tvalid = send;
    rq_axis_tlast = send;
    rq_axis_tkeep = send ? KEEP : '0;
    rq_axis_tdata = '0;
    rq_axis_tuser = '0;
    if (send) begin
      rq_axis_tdata[63:48] = dest_q;
      rq_axis_tdata[74:64] = 11'd2;
      rq_axis_tdata[78:75] = 4'b1110;
      rq_axis_tdata[95:80] = req_id;
      rq_axis_tdata[103:96] = {3'b0, itag_q};
      rq_axis_tdata[111:104] = INV_REQ_CODE;
      rq_axis_tdata[114:112] = 3'b010;
      rq_axis_tdata[191:128] = {addr_q, s_q, 11'b0};
      rq_axis_tuser[21:20] = 2'b01;
      rq_axis_tuser[27:26] = 2'b01;
      rq_axis_tuser[31:28] = 4'd5;
    end
  end
  // Lowest free ITag wins: scan downward so the last hit is the lowest index.
  always_comb begin
    alloc_tag = '0;
    for (int i = 31; i >= 0; i--)
      if (!bitmap_q[i]) alloc_tag = 5'(i);
  end
  // A completion is checked against the pre-allocation bitmap, so one aimed at
  // the ITag being handed out this cycle is reported as spurious.
  always_comb begin
    cmd_fire = cmd_valid && cmd_ready;
    cpl_tag = cq_axis_tdata[100:96];
    cpl_hit = cq_axis_tvalid && cq_axis_tready && |cq_axis_tuser[81:80] &&
              cq_axis_tdata[78:75] == 4'b1110 && cq_axis_tdata[111:104] == INV_CPL_CODE;
    cpl_ok = cpl_hit && bitmap_q[cpl_tag];
    set_mask = cmd_fire ? 32'd1 << alloc_tag : '0;
    clr_mask = cpl_ok ? 32'd1 << cpl_tag : '0;
    bitmap_d = hit ? set_mask : (bitmap_q | set_mask) & ~clr_mask;
    cnt_d = 6'($countones(bitmap_d));
    itag_d = cmd_fire ? alloc_tag : itag_q;
    addr_d = cmd_fire ? cmd_addr[63:12] : addr_q;
    s_d = cmd_fire ? cmd_s : s_q;
    dest_d = cmd_fire ? cmd_dest_id : dest_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      bitmap_q <= '0;
      cnt_q <= '0;
      itag_q <= '0;
      addr_q <= '0;
      s_q <= 1'b0;
      dest_q <= '0;
      done_q <= 1'b0;
      done_itag_q <= '0;
      spur_q <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      cnt_q <= cnt_d;
      itag_q <= itag_d;
      addr_q <= addr_d;
      s_q <= s_d;
      dest_q <= dest_d;
      done_q <= cpl_ok;
      done_itag_q <= cpl_ok ? cpl_tag : '0;
      spur_q <= cpl_hit && !cpl_ok;
    end
  end
`ifdef PCIE_ATS_INV_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic timeout_q;
  // A completion on the deadline cycle counts as progress and pre-empts the timeout.
  always_comb begin
    hit = cnt_q != 6'd0 && !cpl_ok && timer_q == 32'(TIMEOUT_CYCLES - 1);
    timer_d = (cnt_q == 6'd0 || cpl_ok || hit) ? '0 : timer_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    timer_q <= !rst ? '0 : timer_d;
    timeout_q <= rst && hit;
  end
  assign timeout = timeout_q;
`else
  assign hit = 1'b0;
  assign timeout = 1'b0;
`endif
  assign inv_done = done_q;
  assign done_itag = done_itag_q;
  assign spurious = spur_q;
  assign outstanding_cnt = cnt_q;
endmodule

// File: tb/tb_pcie_ats_inv_requester.sv
// tb_pcie_ats_inv_requester: directed self-checking bench for pcie_ats_inv_requester.
module tb_pcie_ats_inv_requester;
`ifdef PCIE_ATS_INV_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 1000000;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_s = 1'b0;
  logic [63:0] cmd_addr = '0;
  logic [15:0] cmd_dest_id = '0, req_id = 16'hABCD;
  logic [511:0] rq_axis_tdata, cq_axis_tdata = '0;
  logic [63:0] rq_axis_tkeep, cq_axis_tkeep = '0;
  logic rq_axis_tvalid, rq_axis_tlast, rq_axis_tready = 1'b1;
  logic [182:0] rq_axis_tuser;
  logic cq_axis_tvalid = 1'b0, cq_axis_tready = 1'b1;
  logic [228:0] cq_axis_tuser = '0;
  logic inv_done, spurious, timeout, idle;
  logic [4:0] done_itag;
  logic [5:0] outstanding_cnt;
  int checks = 0, fails = 0;

  pcie_ats_inv_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_s(cmd_s), .cmd_dest_id(cmd_dest_id), .req_id(req_id), .rq_axis_tdata(rq_axis_tdata),
    .rq_axis_tkeep(rq_axis_tkeep), .rq_axis_tvalid(rq_axis_tvalid), .rq_axis_tlast(rq_axis_tlast),
    .rq_axis_tuser(rq_axis_tuser), .rq_axis_tready(rq_axis_tready), .cq_axis_tdata(cq_axis_tdata),
    .cq_axis_tkeep(cq_axis_tkeep), .cq_axis_tvalid(cq_axis_tvalid), .cq_axis_tready(cq_axis_tready),
    .cq_axis_tuser(cq_axis_tuser), .inv_done(inv_done), .done_itag(done_itag), .spurious(spurious),
    .timeout(timeout), .outstanding_cnt(outstanding_cnt), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic issue_cmd(input logic [63:0] a, input logic s, input logic [15:0] d,
                           output logic [4:0] tag, output logic [511:0] data, output bit ok);
    ok = 0;
    tag = '0;
    data = '0;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
    if (!cmd_ready) return;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_s = s;
    cmd_dest_id = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50 && !(rq_axis_tvalid && rq_axis_tready); i++) @(negedge clk);
    if (!(rq_axis_tvalid && rq_axis_tready)) return;
    data = rq_axis_tdata;
    tag = data[100:96];
    ok = 1;
    @(negedge clk);
  endtask

  task automatic set_cpl(input logic [4:0] tag, input logic [7:0] code);
    cq_axis_tdata = '0;
    cq_axis_tdata[78:75] = 4'b1110;
    cq_axis_tdata[111:104] = code;
    cq_axis_tdata[100:96] = tag;
    cq_axis_tuser = '0;
    cq_axis_tuser[81:80] = 2'b01;
    cq_axis_tvalid = 1'b1;
  endtask

  task automatic send_cpl(input logic [4:0] tag, input logic [7:0] code);
    set_cpl(tag, code);
    @(negedge clk);
    cq_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rq_axis_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b exp 0", rq_axis_tvalid); end
    checks++; if (rq_axis_tdata !== '0 || rq_axis_tkeep !== '0 || rq_axis_tuser !== '0 || rq_axis_tlast !== 1'b0) begin fails++; $display("FAIL reset_rq_fields: tdata %h tkeep %h tuser %h tlast %b exp all 0", rq_axis_tdata, rq_axis_tkeep, rq_axis_tuser, rq_axis_tlast); end
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready: got %b exp 0", cmd_ready); end
    checks++; if ({inv_done, spurious, timeout} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b exp 000", {inv_done, spurious, timeout}); end
    checks++; if (outstanding_cnt !== 6'd0) begin fails++; $display("FAIL reset_cnt: got %0d exp 0", outstanding_cnt); end
    checks++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b exp 1", idle); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL post_reset_cmd_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_basic;
    logic [4:0] tag;
    logic [511:0] data;
    bit ok;
    logic [127:0] hdr;
    hdr = {13'b0, 3'b010, 8'h14, 8'h00, 16'hABCD, 1'b0, 4'b1110, 11'd2, 16'h0100, 48'h0};
    rq_axis_tready = 1'b1;
    issue_cmd(64'h0000_1234_5678_9000, 1'b1, 16'h0100, tag, data, ok);
    checks++; if (!ok || tag !== 5'd0) begin fails++; $display("FAIL basic_itag: ok %0d got %0d exp 0", ok, tag); end
    checks++; if (data[127:0] !== hdr) begin fails++; $display("FAIL basic_header: got %h exp %h", data[127:0], hdr); end
    checks++; if (data[191:128] !== 64'h0000_1234_5678_9800) begin fails++; $display("FAIL basic_payload: got %h exp 0000123456789800", data[191:128]); end
    checks++; if (data[511:192] !== '0) begin fails++; $display("FAIL basic_upper: got %h exp 0", data[511:192]); end
    checks++; if (outstanding_cnt !== 6'd1 || idle !== 1'b0) begin fails++; $display("FAIL basic_cnt: cnt %0d idle %b exp 1 0", outstanding_cnt, idle); end
    cmd_valid = 1'b1;
    cmd_addr = 64'hFFFF_0000_AAAA_B123;
    cmd_s = 1'b0;
    cmd_dest_id = 16'h0200;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (rq_axis_tkeep !== 64'h0000_0000_00FF_FFFF || rq_axis_tlast !== 1'b1) begin fails++; $display("FAIL basic_keep_last: tkeep %h tlast %b exp 00ffffff 1", rq_axis_tkeep, rq_axis_tlast); end
    checks++; if (rq_axis_tuser !== 183'h5410_0000) begin fails++; $display("FAIL basic_tuser: got %h exp 54100000", rq_axis_tuser); end
    checks++; if (rq_axis_tdata[191:128] !== 64'hFFFF_0000_AAAA_B000 || rq_axis_tdata[100:96] !== 5'd1 || rq_axis_tdata[63:48] !== 16'h0200) begin fails++; $display("FAIL basic_second: payload %h itag %0d dest %h exp ffff0000aaaab000 1 0200", rq_axis_tdata[191:128], rq_axis_tdata[100:96], rq_axis_tdata[63:48]); end
    @(negedge clk);
    send_cpl(5'd0, 8'h30);
    checks++; if (inv_done !== 1'b1 || done_itag !== 5'd0 || spurious !== 1'b0) begin fails++; $display("FAIL basic_done: done %b itag %0d spur %b exp 1 0 0", inv_done, done_itag, spurious); end
    send_cpl(5'd1, 8'h30);
    checks++; if (inv_done !== 1'b1 || done_itag !== 5'd1 || outstanding_cnt !== 6'd0) begin fails++; $display("FAIL basic_done2: done %b itag %0d cnt %0d exp 1 1 0", inv_done, done_itag, outstanding_cnt); end
    @(negedge clk);
    checks++; if (inv_done !== 1'b0 || idle !== 1'b1) begin fails++; $display("FAIL basic_pulse_width: done %b idle %b exp 0 1", inv_done, idle); end
  endtask

  task automatic test_backpressure;
    logic [511:0] ref_data;
    int bad;
    bad = 0;
    rq_axis_tready = 1'b0;
    cmd_valid = 1'b1;
    cmd_addr = 64'h0000_00AB_CDEF_1000;
    cmd_s = 1'b0;
    cmd_dest_id = 16'h0042;
    @(negedge clk);
    cmd_valid = 1'b0;
    ref_data = rq_axis_tdata;
    for (int i = 0; i < 10; i++) begin
      if (rq_axis_tvalid !== 1'b1 || rq_axis_tdata !== ref_data) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0 || ref_data[191:128] !== 64'h0000_00AB_CDEF_1000) begin fails++; $display("FAIL bp_stable: unstable cycles %0d payload %h exp 0 00000abcdef1000", bad, ref_data[191:128]); end
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL bp_cmd_ready: got %b exp 0", cmd_ready); end
    rq_axis_tready = 1'b1;
    checks++; if (rq_axis_tvalid !== 1'b1) begin fails++; $display("FAIL bp_cycle11_valid: got %b exp 1", rq_axis_tvalid); end
    @(negedge clk);
    checks++; if (rq_axis_tvalid !== 1'b0 || outstanding_cnt !== 6'd1) begin fails++; $display("FAIL bp_accepted: tvalid %b cnt %0d exp 0 1", rq_axis_tvalid, outstanding_cnt); end
    send_cpl(5'd0, 8'h30);
    @(negedge clk);
  endtask

  task automatic test_full;
    logic [4:0] tag;
    logic [511:0] data;
    bit ok;
    for (int i = 0; i < 32; i++) begin
      issue_cmd(64'h1000 * i, 1'b0, 16'h0001, tag, data, ok);
      checks++; if (!ok || tag !== 5'(i)) begin fails++; $display("FAIL full_itag_%0d: ok %0d got %0d exp %0d", i, ok, tag, i); end
    end
    checks++; if (cmd_ready !== 1'b0 || outstanding_cnt !== 6'd32) begin fails++; $display("FAIL full_block: cmd_ready %b cnt %0d exp 0 32", cmd_ready, outstanding_cnt); end
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rq_axis_tvalid !== 1'b0) begin fails++; $display("FAIL full_no_send: tvalid %b exp 0", rq_axis_tvalid); end
    cmd_valid = 1'b0;
    send_cpl(5'd7, 8'h30);
    checks++; if (inv_done !== 1'b1 || done_itag !== 5'd7 || outstanding_cnt !== 6'd31) begin fails++; $display("FAIL full_cpl7: done %b itag %0d cnt %0d exp 1 7 31", inv_done, done_itag, outstanding_cnt); end
    issue_cmd(64'h0, 1'b0, 16'h0001, tag, data, ok);
    checks++; if (!ok || tag !== 5'd7) begin fails++; $display("FAIL full_realloc: ok %0d got %0d exp 7", ok, tag); end
    for (int i = 0; i < 32; i++) send_cpl(5'(i), 8'h30);
    checks++; if (outstanding_cnt !== 6'd0 || idle !== 1'b1) begin fails++; $display("FAIL full_drain: cnt %0d idle %b exp 0 1", outstanding_cnt, idle); end
    @(negedge clk);
  endtask

  task automatic test_spurious;
    send_cpl(5'd3, 8'h30);
    checks++; if (spurious !== 1'b1 || inv_done !== 1'b0 || outstanding_cnt !== 6'd0) begin fails++; $display("FAIL spur_pulse: spur %b done %b cnt %0d exp 1 0 0", spurious, inv_done, outstanding_cnt); end
    @(negedge clk);
    checks++; if (spurious !== 1'b0) begin fails++; $display("FAIL spur_width: got %b exp 0", spurious); end
    send_cpl(5'd3, 8'h31);
    checks++; if (spurious !== 1'b0 || inv_done !== 1'b0) begin fails++; $display("FAIL spur_wrong_code: spur %b done %b exp 0 0", spurious, inv_done); end
    set_cpl(5'd3, 8'h30);
    cq_axis_tuser[81:80] = 2'b00;
    @(negedge clk);
    cq_axis_tvalid = 1'b0;
    checks++; if (spurious !== 1'b0) begin fails++; $display("FAIL spur_no_tuser: spur %b exp 0", spurious); end
  endtask

  task automatic test_same_cycle;
    cmd_valid = 1'b1;
    cmd_addr = 64'h5000;
    set_cpl(5'd0, 8'h30);
    @(negedge clk);
    cmd_valid = 1'b0;
    cq_axis_tvalid = 1'b0;
    checks++; if (spurious !== 1'b1 || inv_done !== 1'b0 || outstanding_cnt !== 6'd1 || rq_axis_tvalid !== 1'b1) begin fails++; $display("FAIL same_alloc_spur: spur %b done %b cnt %0d tvalid %b exp 1 0 1 1", spurious, inv_done, outstanding_cnt, rq_axis_tvalid); end
    @(negedge clk);
    cmd_valid = 1'b1;
    set_cpl(5'd0, 8'h30);
    @(negedge clk);
    cmd_valid = 1'b0;
    cq_axis_tvalid = 1'b0;
    checks++; if (inv_done !== 1'b1 || done_itag !== 5'd0 || outstanding_cnt !== 6'd1 || rq_axis_tdata[100:96] !== 5'd1) begin fails++; $display("FAIL same_alloc_done: done %b itag %0d cnt %0d new %0d exp 1 0 1 1", inv_done, done_itag, outstanding_cnt, rq_axis_tdata[100:96]); end
    @(negedge clk);
    send_cpl(5'd1, 8'h30);
    checks++; if (outstanding_cnt !== 6'd0) begin fails++; $display("FAIL same_drain: cnt %0d exp 0", outstanding_cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_send;
    logic [4:0] tag;
    logic [511:0] data;
    bit ok;
    for (int i = 0; i < 3; i++) issue_cmd(64'h0, 1'b0, 16'h0, tag, data, ok);
    rq_axis_tready = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (rq_axis_tvalid !== 1'b1 || outstanding_cnt !== 6'd4) begin fails++; $display("FAIL rms_setup: tvalid %b cnt %0d exp 1 4", rq_axis_tvalid, outstanding_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rq_axis_tvalid !== 1'b0 || outstanding_cnt !== 6'd0) begin fails++; $display("FAIL rms_drop: tvalid %b cnt %0d exp 0 0", rq_axis_tvalid, outstanding_cnt); end
    rst = 1'b1;
    rq_axis_tready = 1'b1;
    @(negedge clk);
    issue_cmd(64'h0, 1'b0, 16'h0, tag, data, ok);
    checks++; if (!ok || tag !== 5'd0 || outstanding_cnt !== 6'd1) begin fails++; $display("FAIL rms_realloc: ok %0d tag %0d cnt %0d exp 1 0 1", ok, tag, outstanding_cnt); end
    send_cpl(5'd0, 8'h30);
    @(negedge clk);
  endtask

  task automatic test_timeout;
    logic [4:0] tag;
    logic [511:0] data;
    bit ok;
    int n;
    n = 0;
    issue_cmd(64'h7000, 1'b0, 16'h0, tag, data, ok);
`ifdef PCIE_ATS_INV_TIMEOUT_EN
    while (n < 300 && timeout !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 99) begin fails++; $display("FAIL timeout_delay: got %0d exp 99", n); end
    checks++; if (outstanding_cnt !== 6'd0 || idle !== 1'b1) begin fails++; $display("FAIL timeout_clear: cnt %0d idle %b exp 0 1", outstanding_cnt, idle); end
    @(negedge clk);
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_width: got %b exp 0", timeout); end
`else
    while (n < 300 && timeout !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 300 || outstanding_cnt !== 6'd1) begin fails++; $display("FAIL no_timeout: timeout after %0d cnt %0d exp never 1", n, outstanding_cnt); end
    send_cpl(tag, 8'h30);
    checks++; if (outstanding_cnt !== 6'd0) begin fails++; $display("FAIL no_timeout_drain: cnt %0d exp 0", outstanding_cnt); end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_full();
    test_spurious();
    test_same_cycle();
    test_reset_mid_send();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
